// File: rtl/param_fir_filter.sv
// Time-multiplexed FIR filter: one MAC per clock over N taps, with a writable
// coefficient RAM, a saturating registered output and a dropped-strobe indicator.
module param_fir_filter #(
  parameter int IN_W     = 3,
  parameter int COEF_W   = 16,
  parameter int OUT_W    = 16,
  parameter int MAX_TAPS = 16,
  parameter int SHIFT    = 0,
  localparam int AW      = $clog2(MAX_TAPS),
  localparam int ACC_W   = IN_W + COEF_W + AW
) (
  input  logic                     iClk_12M,
  input  logic                     iRst,
  input  logic                     iEnSample_600k,
  input  logic signed [IN_W-1:0]   iFirIn,
  input  logic                     iCoeffiUpdateFlag,
  input  logic                     iCsnRam,
  input  logic                     iWrnRam,
  input  logic [AW-1:0]            iAddrRam,
  input  logic signed [COEF_W-1:0] iWrDtRam,
  input  logic [AW:0]              iNumOfCoeff,
  output logic signed [OUT_W-1:0]  oFirOut,
  output logic                     oValid,
  output logic                     oBusy,
  output logic                     oOverrun
);

  typedef enum logic [1:0] {IDLE, UPDATE, ACC, DONE} state_t;

  localparam logic [AW:0] MAX_N = (AW+1)'(MAX_TAPS);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  state_t state, state_nxt;

  logic signed [IN_W-1:0]         x    [MAX_TAPS];
  logic signed [COEF_W-1:0]       coef [MAX_TAPS];
  logic [AW:0]                    k, k_inc, n_lat, n_clamped;
  logic [AW-1:0]                  k_idx;
  logic signed [ACC_W-1:0]        acc, shifted;
  logic signed [IN_W+COEF_W-1:0]  prod;
  logic signed [OUT_W-1:0]        sat;

  assign n_clamped = (iNumOfCoeff > MAX_N) ? MAX_N : iNumOfCoeff;
  assign k_inc     = k + ONE;
  assign k_idx     = k[AW-1:0];
  assign prod      = x[k_idx] * coef[k_idx];
  assign shifted   = acc >>> SHIFT;

  generate
    if (ACC_W > OUT_W) begin : g_sat
      localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        sat = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX)      sat = {1'b0, {(OUT_W-1){1'b1}}};
        else if (shifted < SAT_MIN) sat = {1'b1, {(OUT_W-1){1'b0}}};
      end
    end else begin : g_nosat
      always_comb sat = OUT_W'(shifted);
    end
  endgenerate

  always_ff @(posedge iClk_12M) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (iCoeffiUpdateFlag)   state_nxt = UPDATE;
        else if (iEnSample_600k) state_nxt = (n_clamped == '0) ? DONE : ACC;
      end
      UPDATE: if (!iCoeffiUpdateFlag) state_nxt = IDLE;
      ACC:    if (k_inc == n_lat)     state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      for (int unsigned i = 0; i < MAX_TAPS; i++) begin
        x[i]    <= '0;
        coef[i] <= '0;
      end
      acc      <= '0;
      k        <= '0;
      n_lat    <= '0;
      oFirOut  <= '0;
      oValid   <= 1'b0;
      oOverrun <= 1'b0;
    end else begin
      oValid   <= 1'b0;
      oOverrun <= iEnSample_600k && (state == ACC || state == DONE);
      case (state)
        IDLE: begin
          if (!iCoeffiUpdateFlag && iEnSample_600k) begin
            x[0] <= iFirIn;
            for (int unsigned i = 1; i < MAX_TAPS; i++) x[i] <= x[i-1];
            n_lat <= n_clamped;
            acc   <= '0;
            k     <= '0;
          end
        end
        UPDATE: begin
          if (!iCsnRam && !iWrnRam && ({1'b0, iAddrRam} < MAX_N))
            coef[iAddrRam] <= iWrDtRam;
        end
        ACC: begin
          acc <= acc + ACC_W'(prod);
          k   <= k_inc;
        end
        DONE: begin
          oFirOut <= sat;
          oValid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign oBusy = (state == ACC) || (state == DONE);

endmodule

// File: doc/param_fir_filter.md
PARAM_FIR_FILTER -- requirements
Module: param_fir_filter

Interface
REQ-001 SHALL expose parameter IN_W, default 3, signed input sample width.
REQ-002 SHALL expose parameter COEF_W, default 16, signed coefficient width.
REQ-003 SHALL expose parameter OUT_W, default 16, signed output width.
REQ-004 SHALL expose parameter MAX_TAPS, default 16, coefficient RAM depth and delay-line length.
REQ-005 SHALL expose parameter SHIFT, default 0, arithmetic right shift applied to the accumulator before output.
REQ-006 SHALL derive AW = clog2(MAX_TAPS) and ACC_W = IN_W+COEF_W+AW internally.
REQ-007 iClk_12M  in  1  single system clock; all logic on its rising edge.
REQ-008 iRst  in  1  reset, synchronous, active-high.
REQ-009 iEnSample_600k  in  1  one-cycle sample strobe.
REQ-010 iFirIn  in  IN_W  signed input sample, valid with iEnSample_600k.
REQ-011 iCoeffiUpdateFlag  in  1  coefficient-update mode request (level).
REQ-012 iCsnRam  in  1  RAM chip select, active-low.
REQ-013 iWrnRam  in  1  RAM write enable, active-low.
REQ-014 iAddrRam  in  AW  coefficient address.
REQ-015 iWrDtRam  in  COEF_W  signed coefficient write data.
REQ-016 iNumOfCoeff  in  AW+1  active tap count N.
REQ-017 oFirOut  out  OUT_W  signed filtered output, registered.
REQ-018 oValid  out  1  one-cycle pulse when oFirOut updates.
REQ-019 oBusy  out  1  high while state is ACC or DONE.
REQ-020 oOverrun  out  1  one-cycle pulse when a sample strobe is dropped.

Function
REQ-021 SHALL implement FSM states IDLE, UPDATE, ACC, DONE.
REQ-022 IDLE: iCoeffiUpdateFlag=1 -> UPDATE (priority); else iEnSample_600k=1 -> shift iFirIn into delay line x[0] (x[k]<=x[k-1]), latch N, clear accumulator and tap counter k, go ACC.
REQ-023 UPDATE: each cycle with iCsnRam=0 and iWrnRam=0 SHALL write iWrDtRam to coef[iAddrRam]; addresses >= MAX_TAPS ignored; iCoeffiUpdateFlag=0 -> IDLE.
REQ-024 UPDATE: sample strobes ignored, delay line unchanged, no oOverrun.
REQ-025 ACC: one product per cycle, acc += coef[k]*x[k], k = 0..N-1; after k=N-1 -> DONE.
REQ-026 DONE: oFirOut <= sat(acc >>> SHIFT), oValid=1 for that cycle, -> IDLE.
REQ-027 Latency: strobe at cycle 0 -> oValid at cycle N+1; next strobe accepted from cycle N+2.
REQ-028 Latched N=0 SHALL skip ACC (IDLE -> DONE) and output 0; N>MAX_TAPS SHALL clamp to MAX_TAPS.
REQ-029 N latched at strobe; iNumOfCoeff changes during ACC SHALL not affect the current result.
REQ-030 Strobe during ACC or DONE SHALL be dropped and pulse oOverrun next cycle; current result unaffected.
REQ-031 iCoeffiUpdateFlag asserted during ACC/DONE SHALL not abort; UPDATE entered from IDLE after DONE.
REQ-032 Products IN_W+COEF_W signed, accumulator ACC_W signed, no internal overflow.
REQ-033 Saturation: result > 2^(OUT_W-1)-1 -> max positive; < -2^(OUT_W-1) -> min negative.
REQ-034 oFirOut SHALL hold its value between oValid pulses.

Reset
REQ-035 iRst=1 SHALL, at the next clock edge, force IDLE, clear delay line, coefficient RAM, accumulator, k, and set oFirOut=0, oValid=0, oBusy=0, oOverrun=0.
REQ-036 Reset mid-ACC SHALL discard the partial sum; no oValid is produced.

Verification
REQ-037 Impulse: coef[0..3]=1,2,3,4, N=4, inputs 1,0,0,0,0 -> oFirOut 1,2,3,4,0, each oValid 5 cycles after its strobe.
REQ-038 Saturation: coef[0..3]=0x7FFF, N=4, input 3 repeated -> 0x7FFF; input -4 repeated -> 0x8000.
REQ-039 Overrun: strobe 2 cycles after an accepted strobe (N=4) -> oOverrun pulse, sample absent from delay line, pending result unchanged.
REQ-040 Update: flag set during ACC -> result completes, then UPDATE; write to address MAX_TAPS ignored, write coef[1]=5 read back via impulse output.
REQ-041 Boundaries: N=0 -> oValid with 0 one cycle after strobe; N=MAX_TAPS+5 behaves as N=MAX_TAPS.
REQ-042 Reset mid-ACC -> next cycle all outputs 0, no oValid, next impulse yields clean response.
